// File: rtl/player_motion_pkg.sv
// Shared definitions for the player motion stage: phase encoding, packed
// player-state layout and the default playfield constants.
package player_pkg;

    typedef enum logic [1:0] {
        PH_LOAD     = 2'd0,
        PH_GROUNDED = 2'd1,
        PH_RISING   = 2'd2,
        PH_FALLING  = 2'd3
    } phase_e;

    localparam int POS_W = 10;
    localparam int SPD_W = 5;

    // Field order matches the 32-bit packing: {xPos,yPos,xSpeed,ySpeed,xDir,yDir}.
    // xdir 1 = moving right, ydir 1 = moving up.
    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
        logic [SPD_W-1:0] xs;
        logic [SPD_W-1:0] ys;
        logic             xdir;
        logic             ydir;
    } pstate_t;

    localparam int LEFT_BOUND_DEF  = 144;
    localparam int RIGHT_BOUND_DEF = 784;
    localparam int TOP_BOUND_DEF   = 35;
    localparam int FLOOR_Y_DEF     = 450;
    localparam int SPRITE_W_DEF    = 32;
    localparam int JUMP_SPEED_DEF  = 12;
    localparam int MAX_FALL_DEF    = 10;

endpackage

// File: rtl/player_motion_if.sv
// Control/state bundle between the game controller (master) and the
// player motion stage (slave).
interface player_motion_if;

    logic        tick;
    logic        restart;
    logic [31:0] init_state;
    logic        jump_btn;
    logic [31:0] player_state;
    logic        grounded;
    logic [1:0]  phase;

    modport master (
        output tick, restart, init_state, jump_btn,
        input  player_state, grounded, phase
    );

    modport slave (
        input  tick, restart, init_state, jump_btn,
        output player_state, grounded, phase
    );

endinterface

// File: rtl/player_motion_x_mover.sv
// Horizontal auto-walk step: advance x by xSpeed in the current direction,
// clamp at the walls and bounce. Purely combinational.
module player_x_mover
    import player_pkg::*;
#(
    parameter int LEFT_BOUND  = LEFT_BOUND_DEF,
    parameter int RIGHT_BOUND = RIGHT_BOUND_DEF,
    parameter int SPRITE_W    = SPRITE_W_DEF
) (
    input  logic [POS_W-1:0] x_i,
    input  logic [SPD_W-1:0] xs_i,
    input  logic             xdir_i,
    output logic [POS_W-1:0] x_o,
    output logic             xdir_o
);

    localparam logic [10:0] X_MAX = 11'(RIGHT_BOUND - SPRITE_W);
    localparam logic [10:0] X_MIN = 11'(LEFT_BOUND);

    logic [10:0] x_sum;
    logic [10:0] x_diff;

    // One-bit-wider sum/difference so overflow and underflow are visible.
    always_comb begin
        x_sum  = {1'b0, x_i} + {6'b0, xs_i};
        x_diff = {1'b0, x_i} - {6'b0, xs_i};
        x_o    = x_i;
        xdir_o = xdir_i;
        if (xdir_i) begin
            if (x_sum >= X_MAX) begin
                x_o    = X_MAX[9:0];
                xdir_o = 1'b0;
            end else begin
                x_o = x_sum[9:0];
            end
        end else begin
            if (x_diff[10] || (x_diff <= X_MIN)) begin
                x_o    = X_MIN[9:0];
                xdir_o = 1'b1;
            end else begin
                x_o = x_diff[9:0];
            end
        end
    end

endmodule

// File: rtl/player_motion.sv
// Per-frame player physics: loads the initial state, then on each tick moves
// the player horizontally (wall bounce) and vertically (jump/gravity/floor/
// ceiling). Optional feature macro: DOUBLE_JUMP_EN (one extra jump per
// airtime; when undefined an airborne jump request is held until landing).
//
//   state       | meaning
//   ------------+-------------------------------------------------
//   PH_LOAD     | copy init_state on the next clock, pick landing phase
//   PH_GROUNDED | on the floor, a pending jump request launches
//   PH_RISING   | moving up, speed decays by 1 per tick
//   PH_FALLING  | moving down, speed grows to MAX_FALL, lands on floor
module player_motion
    import player_pkg::*;
#(
    parameter int LEFT_BOUND  = LEFT_BOUND_DEF,
    parameter int RIGHT_BOUND = RIGHT_BOUND_DEF,
    parameter int TOP_BOUND   = TOP_BOUND_DEF,
    parameter int FLOOR_Y     = FLOOR_Y_DEF,
    parameter int SPRITE_W    = SPRITE_W_DEF,
    parameter int JUMP_SPEED  = JUMP_SPEED_DEF,
    parameter int MAX_FALL    = MAX_FALL_DEF
) (
    input  logic           sim_clk,
    input  logic           reset,
    player_motion_if.slave bus
);

    localparam logic [9:0]  FLOOR_Q = 10'(FLOOR_Y);
    localparam logic [10:0] FLOOR_W = 11'(FLOOR_Y);
    localparam logic [9:0]  TOP_Q   = 10'(TOP_BOUND);
    localparam logic [10:0] TOP_W   = 11'(TOP_BOUND);
    localparam logic [9:0]  JUMP_Q  = 10'(JUMP_SPEED);
    localparam logic [4:0]  JUMP_YS = 5'(JUMP_SPEED - 1);
    localparam logic [4:0]  MAXF_Q  = 5'(MAX_FALL);

    pstate_t     st_q;
    pstate_t     ld_state;
    phase_e      phase_q;
    phase_e      phase_d;
    logic        btn_q;
    logic        jump_req_q;
    logic        jump_req_d;
    logic        btn_rise;
    logic        req;
    logic        load_grounded;
    logic [9:0]  x_next;
    logic        xdir_next;
    logic [9:0]  y_d;
    logic [4:0]  ys_d;
    logic        ydir_d;
    logic [10:0] y_up;
    logic [10:0] y_dn;
    logic        take_jump;
    logic        air_jump;
    logic        go_fall;
    logic        go_land;
`ifdef DOUBLE_JUMP_EN
    logic        air_used_q;
    logic        air_used_d;
`endif

    assign btn_rise = bus.jump_btn & ~btn_q;
    // A rising edge coincident with a tick counts for that same tick.
    assign req      = jump_req_q | btn_rise;
    assign y_up     = {1'b0, st_q.y} - {6'b0, st_q.ys};
    assign y_dn     = {1'b0, st_q.y} + {6'b0, st_q.ys};

    player_x_mover #(
        .LEFT_BOUND  (LEFT_BOUND),
        .RIGHT_BOUND (RIGHT_BOUND),
        .SPRITE_W    (SPRITE_W)
    ) u_x_mover (
        .x_i    (st_q.x),
        .xs_i   (st_q.xs),
        .xdir_i (st_q.xdir),
        .x_o    (x_next),
        .xdir_o (xdir_next)
    );

    // Initial state as loaded: a spawn at or below the floor snaps onto it.
    always_comb begin
        ld_state      = pstate_t'(bus.init_state);
        load_grounded = 1'b0;
        if (ld_state.y >= FLOOR_Q) begin
            ld_state.y    = FLOOR_Q;
            ld_state.ys   = '0;
            load_grounded = 1'b1;
        end
    end

    // Vertical step for the current phase, evaluated every cycle, applied on tick.
    always_comb begin
        y_d       = st_q.y;
        ys_d      = st_q.ys;
        ydir_d    = st_q.ydir;
        go_fall   = 1'b0;
        go_land   = 1'b0;
        air_jump  = 1'b0;
`ifdef DOUBLE_JUMP_EN
        air_jump  = req & ~air_used_q &
                    ((phase_q == PH_RISING) | (phase_q == PH_FALLING));
`endif
        take_jump = air_jump | ((phase_q == PH_GROUNDED) & req);
        if (take_jump) begin
            y_d    = st_q.y - JUMP_Q;
            ys_d   = JUMP_YS;
            ydir_d = 1'b1;
        end else begin
            case (phase_q)
                PH_RISING: begin
                    if (y_up[10] || (y_up < TOP_W)) begin
                        y_d     = TOP_Q;
                        ys_d    = '0;
                        ydir_d  = 1'b0;
                        go_fall = 1'b1;
                    end else begin
                        y_d  = y_up[9:0];
                        ys_d = (st_q.ys == 5'd0) ? 5'd0 : st_q.ys - 5'd1;
                        if (ys_d == 5'd0) begin
                            ydir_d  = 1'b0;
                            go_fall = 1'b1;
                        end
                    end
                end
                PH_FALLING: begin
                    if (y_dn >= FLOOR_W) begin
                        y_d     = FLOOR_Q;
                        ys_d    = '0;
                        go_land = 1'b1;
                    end else begin
                        y_d  = y_dn[9:0];
                        ys_d = (st_q.ys >= MAXF_Q) ? MAXF_Q : st_q.ys + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Phase register.
    always_ff @(posedge sim_clk or posedge reset) begin
        if (reset) begin
            phase_q <= PH_LOAD;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Next phase: restart wins, LOAD always resolves in one clock, motion on tick.
    always_comb begin
        phase_d = phase_q;
        if (bus.restart) begin
            phase_d = PH_LOAD;
        end else if (phase_q == PH_LOAD) begin
            phase_d = load_grounded ? PH_GROUNDED : PH_FALLING;
        end else if (bus.tick) begin
            if (take_jump) begin
                phase_d = PH_RISING;
            end else if (go_fall) begin
                phase_d = PH_FALLING;
            end else if (go_land) begin
                phase_d = PH_GROUNDED;
            end
        end
    end

    // Jump request bookkeeping: cleared on (re)load or when a tick consumes it.
    always_comb begin
        jump_req_d = req;
        if (bus.restart || (phase_q == PH_LOAD)) begin
            jump_req_d = 1'b0;
        end else if (bus.tick && take_jump) begin
            jump_req_d = 1'b0;
        end
    end

`ifdef DOUBLE_JUMP_EN
    // Air-jump allowance: used by an airborne jump, restored on landing or load.
    always_comb begin
        air_used_d = air_used_q;
        if (bus.restart || (phase_q == PH_LOAD)) begin
            air_used_d = 1'b0;
        end else if (bus.tick && air_jump) begin
            air_used_d = 1'b1;
        end else if (bus.tick && go_land) begin
            air_used_d = 1'b0;
        end
    end

    // Air-jump allowance register.
    always_ff @(posedge sim_clk or posedge reset) begin
        if (reset) begin
            air_used_q <= 1'b0;
        end else begin
            air_used_q <= air_used_d;
        end
    end
`endif

    // Player state, button history and pending jump registers.
    always_ff @(posedge sim_clk or posedge reset) begin
        if (reset) begin
            st_q       <= '0;
            btn_q      <= 1'b0;
            jump_req_q <= 1'b0;
        end else begin
            btn_q      <= bus.jump_btn;
            jump_req_q <= jump_req_d;
            if (!bus.restart) begin
                if (phase_q == PH_LOAD) begin
                    st_q <= ld_state;
                end else if (bus.tick) begin
                    st_q <= '{x: x_next, y: y_d, xs: st_q.xs, ys: ys_d,
                              xdir: xdir_next, ydir: ydir_d};
                end
            end
        end
    end

    // Outputs are straight from registers, so reset is visible immediately.
    always_comb begin
        bus.player_state = st_q;
        bus.grounded     = (phase_q == PH_GROUNDED);
        bus.phase        = phase_q;
    end

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: vector table for single-step physics
// cases plus hand-written jump / reset / restart sequences.
module tb_player_motion;

    localparam logic [1:0] P_LOAD     = 2'd0;
    localparam logic [1:0] P_GROUNDED = 2'd1;
    localparam logic [1:0] P_RISING   = 2'd2;
    localparam logic [1:0] P_FALLING  = 2'd3;

    logic sim_clk = 1'b0;
    logic reset   = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    player_motion_if bus();

    player_motion dut (
        .sim_clk (sim_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 sim_clk = ~sim_clk;

    typedef struct {
        string       name;
        logic [31:0] st;
        logic [1:0]  ph;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] init;
        int          nticks;
        logic [31:0] exp_st;
        logic [1:0]  exp_ph;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    function automatic logic [31:0] pk(int x, int y, int xs, int ys, int xd, int yd);
        return {10'(x), 10'(y), 5'(xs), 5'(ys), 1'(xd), 1'(yd)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    task automatic push(input string nm, input logic [31:0] st, input logic [1:0] ph);
        sb.push_back('{nm, st, ph});
    endtask

    // One clock with the given tick/restart; pending expectations are checked #1 after the edge.
    task automatic step(input logic t, input logic r);
        exp_t e;
        bus.tick    = t;
        bus.restart = r;
        @(posedge sim_clk);
        #1;
        bus.tick    = 1'b0;
        bus.restart = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.name, "_state"}, bus.player_state, e.st);
            chk({e.name, "_phase"}, {30'd0, bus.phase}, {30'd0, e.ph});
            chk({e.name, "_grounded"}, {31'd0, bus.grounded}, {31'd0, e.ph == P_GROUNDED});
        end
    endtask

    task automatic reload(input logic [31:0] init);
        bus.init_state = init;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
    endtask

    initial begin
        int n;
        int bad;
        bit landed;

        bus.tick       = 1'b0;
        bus.restart    = 1'b0;
        bus.jump_btn   = 1'b0;
        bus.init_state = pk(176, 98, 4, 0, 1, 0);

        vecs.push_back('{"right_wall",    pk(750, 98, 4, 0, 1, 0),  1, pk(752, 98, 4, 1, 0, 0),  P_FALLING});
        vecs.push_back('{"left_wall",     pk(146, 98, 4, 0, 0, 0),  1, pk(144, 98, 4, 1, 1, 0),  P_FALLING});
        vecs.push_back('{"left_underflow",pk(10, 98, 20, 0, 0, 0),  1, pk(144, 98, 20, 1, 1, 0), P_FALLING});
        vecs.push_back('{"right_exact",   pk(748, 98, 4, 0, 1, 0),  1, pk(752, 98, 4, 1, 0, 0),  P_FALLING});
        vecs.push_back('{"left_exact",    pk(148, 98, 4, 0, 0, 0),  1, pk(144, 98, 4, 1, 1, 0),  P_FALLING});
        vecs.push_back('{"land",          pk(300, 446, 0, 5, 0, 0), 1, pk(300, 450, 0, 0, 0, 0), P_GROUNDED});
        vecs.push_back('{"near_floor",    pk(300, 440, 0, 9, 0, 0), 1, pk(300, 449, 0, 10, 0, 0),P_FALLING});
        vecs.push_back('{"fall_saturate", pk(300, 100, 0, 10, 0, 0),1, pk(300, 110, 0, 10, 0, 0),P_FALLING});
        vecs.push_back('{"load_below",    pk(300, 500, 0, 7, 1, 0), 0, pk(300, 450, 0, 0, 1, 0), P_GROUNDED});
        vecs.push_back('{"load_at_floor", pk(200, 450, 3, 0, 1, 0), 1, pk(203, 450, 3, 0, 1, 0), P_GROUNDED});
        vecs.push_back('{"load_above",    pk(200, 449, 0, 0, 1, 0), 0, pk(200, 449, 0, 0, 1, 0), P_FALLING});
        vecs.push_back('{"two_ticks",     pk(400, 445, 2, 3, 0, 0), 2, pk(396, 450, 2, 0, 0, 0), P_GROUNDED});

        // Reset held across clock edges.
        repeat (2) @(posedge sim_clk);
        #1;
        chk("reset_state", bus.player_state, 32'd0);
        chk("reset_phase", {30'd0, bus.phase}, {30'd0, P_LOAD});
        chk("reset_grounded", {31'd0, bus.grounded}, 32'd0);
        @(negedge sim_clk);
        reset = 1'b0;

        // First clock after reset loads init.
        push("load_init", pk(176, 98, 4, 0, 1, 0), P_FALLING);
        step(1'b0, 1'b0);
        push("tick1", pk(180, 98, 4, 1, 1, 0), P_FALLING);
        step(1'b1, 1'b0);
        push("tick2", pk(184, 99, 4, 2, 1, 0), P_FALLING);
        step(1'b1, 1'b0);

        foreach (vecs[i]) begin
            bus.init_state = vecs[i].init;
            step(1'b0, 1'b1);
            chk({vecs[i].name, "_restart_phase"}, {30'd0, bus.phase}, {30'd0, P_LOAD});
            if (vecs[i].nticks == 0) push(vecs[i].name, vecs[i].exp_st, vecs[i].exp_ph);
            step(1'b0, 1'b0);
            for (int k = 1; k <= vecs[i].nticks; k++) begin
                if (k == vecs[i].nticks) push(vecs[i].name, vecs[i].exp_st, vecs[i].exp_ph);
                step(1'b1, 1'b0);
            end
        end

        // Jump from ground, button then held through the whole airtime.
        reload(pk(300, 450, 0, 0, 0, 0));
        bus.jump_btn = 1'b1;
        step(1'b0, 1'b0);
        push("jump", pk(300, 438, 0, 11, 0, 1), P_RISING);
        step(1'b1, 1'b0);
        n = 0;
        landed = 1'b0;
        for (int k = 0; k < 60 && !landed; k++) begin
            step(1'b1, 1'b0);
            n++;
            if (bus.phase == P_GROUNDED) landed = 1'b1;
        end
        chk("jump_airtime_ticks", 32'(n), 32'd25);
        chk("jump_landed_state", bus.player_state, pk(300, 450, 0, 0, 0, 0));
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0);
            if (bus.phase != P_GROUNDED) bad++;
        end
        chk("held_btn_no_rejump", 32'(bad), 32'd0);

        // Button edge on the same cycle as the tick.
        bus.jump_btn = 1'b0;
        step(1'b0, 1'b0);
        bus.jump_btn = 1'b1;
        push("jump_same_cycle", pk(300, 438, 0, 11, 0, 1), P_RISING);
        step(1'b1, 1'b0);

        // Async reset mid-rising, between clock edges.
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_state", bus.player_state, 32'd0);
        chk("async_reset_phase", {30'd0, bus.phase}, {30'd0, P_LOAD});
        bus.jump_btn   = 1'b0;
        bus.init_state = pk(300, 450, 5, 0, 1, 0);
        @(negedge sim_clk);
        reset = 1'b0;
        push("post_reset_load", pk(300, 450, 5, 0, 1, 0), P_GROUNDED);
        step(1'b0, 1'b0);
        push("ground_walk", pk(305, 450, 5, 0, 1, 0), P_GROUNDED);
        step(1'b1, 1'b0);
        push("restart_and_tick", pk(305, 450, 5, 0, 1, 0), P_LOAD);
        step(1'b1, 1'b1);
        push("restart_reload", pk(300, 450, 5, 0, 1, 0), P_GROUNDED);
        step(1'b0, 1'b0);

        // Jump pressed while falling.
        reload(pk(300, 446, 0, 5, 0, 0));
        bus.jump_btn = 1'b1;
        step(1'b0, 1'b0);
`ifdef DOUBLE_JUMP_EN
        push("air_jump", pk(300, 434, 0, 11, 0, 1), P_RISING);
        step(1'b1, 1'b0);
        bus.jump_btn = 1'b0;
        step(1'b0, 1'b0);
        bus.jump_btn = 1'b1;
        push("second_air_jump_ignored", pk(300, 423, 0, 10, 0, 1), P_RISING);
        step(1'b1, 1'b0);
`else
        push("air_press_land", pk(300, 450, 0, 0, 0, 0), P_GROUNDED);
        step(1'b1, 1'b0);
        push("buffered_jump", pk(300, 438, 0, 11, 0, 1), P_RISING);
        step(1'b1, 1'b0);
`endif
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
